wb_uart_tx: RTL and testbench



---
 rtl/wb_uart_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-slave 8N1 UART transmitter with byte FIFO, baud divisor and status.
// Optional feature macro: WB_UART_TX_IRQ_EN adds o_irq and STATUS.irq_en (bit16).
module wb_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_RESET  = 868
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx
`ifdef WB_UART_TX_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 16;

  localparam logic [1:0] ADR_TXDATA  = 2'd0;
  localparam logic [1:0] ADR_STATUS  = 2'd1;
  localparam logic [1:0] ADR_DIVISOR = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   fdiv_q, fdiv_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic [DW-1:0]   div_q, div_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdt_q, rdt_d;
  logic            irq_en_q, irq_en_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            acc_c, wr_c, push_c, pop_c, load_c, tick_c;
  logic            empty_c, full_c;
  logic [PW-1:0]   count_c;
  logic [31:0]     status_c;
  logic            unused_c;

  // Byte select and upper data bits carry no meaning for this block
  assign unused_c = ^{i_wb_sel, i_wb_dat[31:16]};

  assign count_c = wptr_q - rptr_q;
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_tx     = tx_q;

  // Bus decode, register writes, FIFO pointers and read-data mux
  always_comb begin
    acc_c    = i_wb_cyc & ~ack_q;
    wr_c     = acc_c & i_wb_we;
    ack_d    = acc_c;
    push_c   = wr_c && (i_wb_adr == ADR_TXDATA) && !full_c;
    ovf_d    = ovf_q;
    div_d    = div_q;
    irq_en_d = irq_en_q;
    rdt_d    = '0;

    if (wr_c && (i_wb_adr == ADR_TXDATA) && full_c) begin
      ovf_d = 1'b1;
    end else if (wr_c && (i_wb_adr == ADR_STATUS) && i_wb_dat[3]) begin
      ovf_d = 1'b0;
    end

    if (wr_c && (i_wb_adr == ADR_DIVISOR)) begin
      div_d = (i_wb_dat[DW-1:0] < 16'd2) ? 16'd2 : i_wb_dat[DW-1:0];
    end

`ifdef WB_UART_TX_IRQ_EN
    if (wr_c && (i_wb_adr == ADR_STATUS)) begin
      irq_en_d = i_wb_dat[16];
    end
`endif

    wptr_d = wptr_q + PW'(push_c);
    rptr_d = rptr_q + PW'(pop_c);

    status_c = {15'd0, irq_en_q, 8'(count_c), 4'd0,
                ovf_q, full_c, empty_c, (state_q != ST_IDLE)};

    if (acc_c) begin
      case (i_wb_adr)
        ADR_STATUS:  rdt_d = status_c;
        ADR_DIVISOR: rdt_d = {16'd0, div_q};
        default:     rdt_d = '0;
      endcase
    end
  end

  // TX FSM: next state, bit timer, shift register and line level
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fdiv_d    = fdiv_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    pop_c     = 1'b0;
    load_c    = 1'b0;
    tx_d      = 1'b1;
    tick_c    = (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        load_c = !empty_c;
      end
      ST_START: begin
        if (tick_c) begin
          cnt_d     = fdiv_q - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          cnt_d   = fdiv_q - 16'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (!empty_c) begin
            load_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start: pop head, latch divisor so mid-frame writes wait for the next frame
    if (load_c) begin
      pop_c   = 1'b1;
      shreg_d = mem_q[rptr_q[AW-1:0]];
      fdiv_d  = div_q;
      cnt_d   = div_q - 16'd1;
      state_d = ST_START;
    end

    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State and register update
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fdiv_q    <= 16'(DIV_RESET);
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      div_q     <= 16'(DIV_RESET);
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ack_q     <= 1'b0;
      rdt_q     <= '0;
      irq_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fdiv_q    <= fdiv_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
      irq_en_q  <= irq_en_d;
    end
  end

  // FIFO storage, no reset needed: pointers define validity
  always_ff @(posedge wb_clk) begin
    if (push_c) begin
      mem_q[wptr_q[AW-1:0]] <= i_wb_dat[7:0];
    end
  end

`ifdef WB_UART_TX_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt when everything queued has been sent
  always_comb begin
    irq_d = irq_en_q & empty_c & (state_q == ST_IDLE);
  end

  // Interrupt output register
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: self-checking bench for wb_uart_tx with a line-level UART receiver model.
module tb_wb_uart_tx;

  localparam int DEPTH  = 16;
  localparam int DIVRST = 868;

  localparam logic [1:0] A_TX  = 2'd0;
  localparam logic [1:0] A_ST  = 2'd1;
  localparam logic [1:0] A_DIV = 2'd2;
  localparam logic [1:0] A_RSV = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] rdt;
  logic        ack;
  logic        tx;
`ifdef WB_UART_TX_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [9:0] bits;
    int         start;
    bit         ok;
  } frame_t;

  frame_t rx_q[$];
  int     exp_div_q[$];
  int     unexpected = 0;

  wb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVRST)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .o_wb_rdt (rdt),
    .o_wb_ack (ack),
    .o_tx     (tx)
`ifdef WB_UART_TX_IRQ_EN
    ,
    .o_irq    (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Line receiver: decodes 8N1 frames using the divisor the test expects for each frame
  initial begin : rx_mon
    logic   prev;
    frame_t f;
    int     div;
    bit     aborted;
    logic   cur;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst_n !== 1'b1) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && tx === 1'b0) begin
        if (exp_div_q.size() == 0) begin
          unexpected++;
          prev = tx;
        end else begin
          div = exp_div_q.pop_front();
          f.start = cyc_cnt;
          f.ok = 1'b1;
          f.bits = '0;
          aborted = 1'b0;
          cur = 1'b0;
          for (int i = 0; i < 10 * div; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
            if (i % div == 0) begin
              cur = tx;
              f.bits = {cur, f.bits[9:1]};
            end else if (tx !== cur) begin
              f.ok = 1'b0;
            end
          end
          if (!aborted) rx_q.push_back(f);
          prev = aborted ? 1'b1 : tx;
        end
      end else begin
        prev = tx;
      end
    end
  end

  function automatic logic [31:0] status_word(bit busy, bit empty, bit full, bit ovf,
                                              int cnt, bit ien);
    logic [31:0] w;
    w = '0;
    w[0] = busy; w[1] = empty; w[2] = full; w[3] = ovf;
    w[15:8] = 8'(cnt);
    w[16] = ien;
    return w;
  endfunction

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, output int ack_cyc);
    @(negedge clk);
    wb_adr = adr; wb_dat = dat; wb_we = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL write_ack adr=%0d: ack=%b expected 1", adr, ack);
    end
    ack_cyc = cyc_cnt;
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] adr, input logic [31:0] dat);
    int c;
    wb_write(adr, dat, c);
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] data);
    @(negedge clk);
    wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL read_ack adr=%0d: ack=%b expected 1", adr, ack);
    end
    data = rdt;
    @(negedge clk);
    wb_cyc = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rx_q.size() >= n) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0; wb_sel = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || ack !== 1'b0 || rdt !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b ack=%b rdt=%h expected 1 0 0", tx, ack, rdt);
    end
`ifdef WB_UART_TX_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%b expected 0", irq); end
`endif
    @(negedge clk); rst_n = 1'b1;
    wb_read(A_ST, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h2); end
    wb_read(A_DIV, d);
    checks++;
    if (d !== 32'(DIVRST)) begin errors++; $display("FAIL reset_divisor: got %0d expected %0d", d, DIVRST); end
    // Single ack pulse: cyc held through the ack cycle must not produce a second-cycle ack
    @(negedge clk); wb_adr = A_ST; wb_cyc = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL ack_pulse_rise: ack=%b expected 1", ack); end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ack_pulse_fall: ack=%b expected 0", ack); end
    @(negedge clk); wb_cyc = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wb_read(A_TX, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h expected 0", d); end
    wb_wr(A_RSV, $urandom);
    wb_read(A_RSV, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reserved_read: got %h expected 0", d); end
    wb_read(A_DIV, d);
    checks++;
    if (d !== 32'(DIVRST)) begin errors++; $display("FAIL reserved_write_divisor: got %0d expected %0d", d, DIVRST); end
`ifndef WB_UART_TX_IRQ_EN
    wb_wr(A_ST, 32'h0001_0000);
    wb_read(A_ST, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL irq_en_absent: got %h expected 2", d); end
`endif
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic [9:0]  e;
    int          ack_c;
    bit          got;
    rx_q.delete();
    wb_wr(A_DIV, 32'd4);
    exp_div_q.push_back(4);
    wb_write(A_TX, 32'hA5, ack_c);
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL latency_n1: tx=%b expected 1 at cycle N+1", tx); end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL latency_n2: tx=%b expected 0 at cycle N+2", tx); end
    wait_rx(1, 100, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL single_frame_timeout: frames=%0d expected 1", rx_q.size());
    end else begin
      e = {1'b1, 8'hA5, 1'b0};
      checks++;
      if (rx_q[0].bits !== e || !rx_q[0].ok) begin
        errors++;
        $display("FAIL single_frame_bits: got %b ok=%0d expected %b ok=1", rx_q[0].bits, rx_q[0].ok, e);
      end
      if (rx_q[0].start != ack_c + 2) begin
        errors++;
        $display("FAIL single_frame_start: start=%0d expected %0d", rx_q[0].start, ack_c + 2);
      end
    end
    repeat (2) @(posedge clk);
    wb_read(A_ST, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL single_frame_idle: status=%h expected 2", d); end
  endtask

  task automatic test_divisor();
    logic [31:0] d;
    logic [7:0]  bx, by;
    bit          got;
    wb_wr(A_DIV, 32'd1);
    wb_read(A_DIV, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL div_clamp1: got %0d expected 2", d); end
    wb_wr(A_DIV, 32'd0);
    wb_read(A_DIV, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL div_clamp0: got %0d expected 2", d); end
    rx_q.delete();
    bx = 8'($urandom); by = 8'($urandom);
    wb_wr(A_DIV, 32'd8);
    exp_div_q.push_back(8);
    wb_wr(A_TX, {24'd0, bx});
    repeat (20) @(posedge clk);
    wb_wr(A_DIV, 32'd4);
    exp_div_q.push_back(4);
    wb_wr(A_TX, {24'd0, by});
    wb_read(A_DIV, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL div_readback: got %0d expected 4", d); end
    wait_rx(2, 300, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL div_latch_timeout: frames=%0d expected 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0].bits !== {1'b1, bx, 1'b0} || !rx_q[0].ok || rx_q[1].bits !== {1'b1, by, 1'b0} || !rx_q[1].ok) begin
        errors++;
        $display("FAIL div_latch_bytes: got %b/%0d %b/%0d expected %b %b", rx_q[0].bits, rx_q[0].ok,
                 rx_q[1].bits, rx_q[1].ok, {1'b1, bx, 1'b0}, {1'b1, by, 1'b0});
      end
      checks++;
      if (rx_q[1].start - rx_q[0].start != 80) begin
        errors++; $display("FAIL div_latch_len: first frame %0d cycles expected 80", rx_q[1].start - rx_q[0].start);
      end
    end
    repeat (3) @(posedge clk);
    wb_read(A_ST, d);
    checks++;
    if (d !== 32'h2 || tx !== 1'b1) begin errors++; $display("FAIL div_latch_idle: status=%h tx=%b expected 2 1", d, tx); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int          ack_c, u0;
    rx_q.delete();
    exp_div_q.push_back(4);
    wb_write(A_TX, 32'h00, ack_c);
    // Line cycle ack+2 is start; ack+12 is mid data bit 1 (zero for 0x00)
    while (cyc_cnt < ack_c + 12) begin @(posedge clk); #1; end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midframe_pre: tx=%b expected 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midframe_async: tx=%b expected 1", tx); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    exp_div_q.delete();
    rx_q.delete();
    u0 = unexpected;
    wb_read(A_ST, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL midframe_status: got %h expected 2", d); end
    wb_read(A_DIV, d);
    checks++;
    if (d !== 32'(DIVRST)) begin errors++; $display("FAIL midframe_divisor: got %0d expected %0d", d, DIVRST); end
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (unexpected != u0 || rx_q.size() != 0 || tx !== 1'b1) begin
      errors++; $display("FAIL midframe_residual: frames=%0d tx=%b expected 0 1", unexpected - u0, tx);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    bit          got;
    int          cap;
    logic [7:0]  exp_b[$];
    rx_q.delete();
    wb_wr(A_DIV, 32'd100);
    // One byte leaves to the shifter immediately, the rest fill the FIFO
    cap = DEPTH + 1;
    for (int i = 0; i < 17; i++) begin
      if (i < cap) begin exp_b.push_back(8'(i)); exp_div_q.push_back(100); end
      wb_wr(A_TX, 32'(i));
    end
    wb_read(A_ST, d);
    checks++;
    if (d !== status_word(1, 0, 1, 0, DEPTH, 0)) begin
      errors++; $display("FAIL fifo_full: status=%h expected %h", d, status_word(1, 0, 1, 0, DEPTH, 0));
    end
    wb_wr(A_TX, 32'hFF);
    wb_read(A_ST, d);
    checks++;
    if (d !== status_word(1, 0, 1, 1, DEPTH, 0)) begin
      errors++; $display("FAIL fifo_overflow: status=%h expected %h", d, status_word(1, 0, 1, 1, DEPTH, 0));
    end
    wb_wr(A_ST, 32'h8);
    wb_read(A_ST, d);
    checks++;
    if (d !== status_word(1, 0, 1, 0, DEPTH, 0)) begin
      errors++; $display("FAIL overflow_clear: status=%h expected %h", d, status_word(1, 0, 1, 0, DEPTH, 0));
    end
    wait_rx(exp_b.size(), 20000, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL fifo_drain_timeout: frames=%0d expected %0d", rx_q.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        checks++;
        if (rx_q[i].bits !== {1'b1, exp_b[i], 1'b0} || !rx_q[i].ok ||
            (i > 0 && rx_q[i].start - rx_q[i-1].start != 1000)) begin
          errors++;
          $display("FAIL fifo_frame%0d: got %b ok=%0d start=%0d expected %b", i, rx_q[i].bits,
                   rx_q[i].ok, rx_q[i].start, {1'b1, exp_b[i], 1'b0});
        end
      end
    end
    repeat (5) @(posedge clk);
    wb_read(A_ST, d);
    checks++;
    if (d !== 32'h2 || unexpected != 0) begin
      errors++; $display("FAIL fifo_after: status=%h extra=%0d expected 2 0", d, unexpected);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  bytes[$];
    int          div, n;
    bit          got;
    for (int r = 0; r < 3; r++) begin
      rx_q.delete();
      bytes.delete();
      div = int'($urandom_range(12, 2));
      wb_wr(A_DIV, {16'($urandom), 16'(div)});
      n = int'($urandom_range(5, 1));
      for (int i = 0; i < n; i++) begin
        bytes.push_back(8'($urandom));
        exp_div_q.push_back(div);
        wb_wr(A_TX, {24'($urandom), bytes[i]});
      end
      wait_rx(n, 10 * 12 * 6 + 100, got);
      checks++;
      if (!got) begin
        errors++; $display("FAIL rand%0d_timeout: frames=%0d expected %0d", r, rx_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (rx_q[i].bits !== {1'b1, bytes[i], 1'b0} || !rx_q[i].ok ||
              (i > 0 && rx_q[i].start - rx_q[i-1].start != 10 * div)) begin
            errors++;
            $display("FAIL rand%0d_frame%0d div=%0d: got %b ok=%0d expected %b", r, i, div,
                     rx_q[i].bits, rx_q[i].ok, {1'b1, bytes[i], 1'b0});
          end
        end
      end
      repeat (3) @(posedge clk);
      wb_read(A_ST, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL rand%0d_status: got %h expected 2", r, d); end
      wb_read(A_DIV, d);
      checks++;
      if (d !== 32'(div)) begin errors++; $display("FAIL rand%0d_div: got %0d expected %0d", r, d, div); end
    end
  endtask

`ifdef WB_UART_TX_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    int          rise, ack_c;
    bit          got;
    rx_q.delete();
    wb_wr(A_DIV, 32'd4);
    wb_wr(A_ST, 32'h0001_0000);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle: irq=%b expected 1", irq); end
    wb_read(A_ST, d);
    checks++;
    if (d !== status_word(0, 1, 0, 0, 0, 1)) begin
      errors++; $display("FAIL irq_en_read: got %h expected %h", d, status_word(0, 1, 0, 0, 0, 1));
    end
    exp_div_q.push_back(4);
    exp_div_q.push_back(4);
    wb_write(A_TX, 32'h3C, ack_c);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_ack_cycle: irq=%b expected 1", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: irq=%b expected 0", irq); end
    wb_wr(A_TX, 32'hC3);
    rise = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1 && rise < 0) rise = cyc_cnt;
      if (rx_q.size() >= 2 && cyc_cnt >= rx_q[1].start + 42) break;
    end
    checks++;
    if (rx_q.size() < 2) begin
      errors++; $display("FAIL irq_frames: frames=%0d expected 2", rx_q.size());
    end else if (rise != rx_q[1].start + 40) begin
      errors++; $display("FAIL irq_rise: rose at %0d expected %0d", rise, rx_q[1].start + 40);
    end
    wb_wr(A_ST, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: irq=%b expected 0", irq); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_regs();
    test_single_frame();
    test_divisor();
    test_reset_midframe();
    test_fifo_overflow();
    test_random();
`ifdef WB_UART_TX_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
